// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: refill FSM states and line/address geometry.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } refill_state_t;

  localparam int BLOCK_WIDTH    = 512;
  localparam int MEM_DATA_WIDTH = 64;
  localparam int BYTE_OFFSET_W  = 2;
  localparam int WORD_OFFSET_W  = 4;
  localparam int INDEX_W        = 8;
  localparam int WORD_COUNT     = 1 << WORD_OFFSET_W;
  localparam int BLOCK_COUNT    = 1 << INDEX_W;
  localparam int BLOCK_OFFSET_W = BYTE_OFFSET_W + WORD_OFFSET_W;

endpackage

// File: rtl/icache_refill_ctrl_line_assembler.sv
// Refill beat counter plus line buffer; beat k lands in bits [k*BEAT_WIDTH +: BEAT_WIDTH].
module icache_refill_ctrl_line_assembler #(
  parameter  int BLOCK_WIDTH = 512,
  parameter  int BEAT_WIDTH  = 64,
  localparam int BEAT_COUNT  = BLOCK_WIDTH / BEAT_WIDTH,
  localparam int IDX_W       = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   i_beat_valid,
  input  logic [BEAT_WIDTH-1:0]  i_beat_data,
  output logic [IDX_W-1:0]       o_beat_idx,
  output logic [BLOCK_WIDTH-1:0] o_line,
  output logic                   o_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEAT_COUNT - 1);

  logic [IDX_W-1:0]       r_beat_idx;
  logic [BLOCK_WIDTH-1:0] r_line;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_beat_idx <= '0;
    end else if (i_beat_valid) begin
      r_beat_idx <= (r_beat_idx == LAST_IDX) ? '0 : r_beat_idx + 1'b1;
    end
  end

  // Data path only: the buffer keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (i_beat_valid) begin
      r_line[int'(r_beat_idx) * BEAT_WIDTH +: BEAT_WIDTH] <= i_beat_data;
    end
  end

  assign o_beat_idx = r_beat_idx;
  assign o_line     = r_line;
  assign o_done     = i_beat_valid & (r_beat_idx == LAST_IDX);

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: stalls fetch on a miss, reads one block, writes the line.
// Optional perf counters o_miss_count / o_refill_cycles are built when ICACHE_REFILL_PERF_EN is defined.
//   state | meaning
//   IDLE  | cache address follows fetch; a valid miss latches the address
//   REQ   | block-aligned read request held until accepted
//   FILL  | collecting beats into the line buffer
//   WRITE | one-cycle cache line write of the assembled block
module icache_refill_ctrl #(
  parameter int ADDR_WIDTH     = 64,
  parameter int BLOCK_WIDTH    = 512,
  parameter int MEM_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      arstn,
  input  logic                      i_fetch_valid,
  input  logic [ADDR_WIDTH-1:0]     i_fetch_addr,
  input  logic                      i_cache_hit,
  output logic                      o_stall,
  output logic [ADDR_WIDTH-1:0]     o_cache_addr,
  output logic                      o_cache_we,
  output logic [BLOCK_WIDTH-1:0]    o_cache_block,
  output logic                      o_mem_req_valid,
  input  logic                      i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0]     o_mem_addr,
  input  logic                      i_mem_rvalid,
  input  logic [MEM_DATA_WIDTH-1:0] i_mem_rdata,
`ifdef ICACHE_REFILL_PERF_EN
  output logic [31:0]               o_miss_count,
  output logic [31:0]               o_refill_cycles,
`endif
  input  logic                      i_mem_rlast
);

  import icache_pkg::*;

  localparam int BEAT_COUNT = BLOCK_WIDTH / MEM_DATA_WIDTH;
  localparam int OFFSET_W   = $clog2(BLOCK_WIDTH / 8);
  localparam int IDX_W      = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEAT_COUNT - 1);

  refill_state_t         r_state;
  logic [ADDR_WIDTH-1:0] r_miss_addr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_req_valid;
  logic                  r_cache_we;

  logic                  w_miss;
  logic                  w_beat_valid;
  logic                  w_line_done;
  logic [IDX_W-1:0]      w_beat_idx;
  logic [BLOCK_WIDTH-1:0] w_line;

  assign w_miss       = i_fetch_valid & ~i_cache_hit;
  assign w_beat_valid = (r_state == FILL) & i_mem_rvalid;

  icache_refill_ctrl_line_assembler #(
    .BLOCK_WIDTH (BLOCK_WIDTH),
    .BEAT_WIDTH  (MEM_DATA_WIDTH)
  ) u_line_assembler (
    .clk          (clk),
    .arstn        (arstn),
    .i_beat_valid (w_beat_valid),
    .i_beat_data  (i_mem_rdata),
    .o_beat_idx   (w_beat_idx),
    .o_line       (w_line),
    .o_done       (w_line_done)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state         <= IDLE;
      r_miss_addr     <= '0;
      r_mem_addr      <= '0;
      r_mem_req_valid <= 1'b0;
      r_cache_we      <= 1'b0;
    end else begin
      r_cache_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_miss_addr     <= i_fetch_addr;
            r_mem_addr      <= {i_fetch_addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
            r_mem_req_valid <= 1'b1;
            r_state         <= REQ;
          end
        end
        REQ: begin
          if (i_mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_state         <= FILL;
          end
        end
        FILL: begin
          if (w_line_done) begin
            r_cache_we <= 1'b1;
            r_state    <= WRITE;
          end
        end
        WRITE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // In IDLE the stall is a same-cycle lookup result so the PC holds on the miss cycle itself.
  assign o_stall         = (r_state == IDLE) ? w_miss : 1'b1;
  assign o_cache_addr    = (r_state == IDLE) ? i_fetch_addr : r_miss_addr;
  assign o_cache_we      = r_cache_we;
  assign o_cache_block   = w_line;
  assign o_mem_req_valid = r_mem_req_valid;
  assign o_mem_addr      = r_mem_addr;

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] r_miss_count;
  logic [31:0] r_refill_cycles;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_miss_count    <= '0;
      r_refill_cycles <= '0;
    end else begin
      if ((r_state == IDLE) && w_miss) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
      if (r_state != IDLE) begin
        r_refill_cycles <= r_refill_cycles + 32'd1;
      end
    end
  end

  assign o_miss_count    = r_miss_count;
  assign o_refill_cycles = r_refill_cycles;
`endif

  // The beat counter decides placement; rlast is only cross-checked against it.
  a_rlast_on_last_beat: assert property (@(posedge clk) disable iff (!arstn)
    ((r_state == FILL) && i_mem_rvalid) |-> (i_mem_rlast == (w_beat_idx == LAST_IDX)));

  a_no_stray_beats: assert property (@(posedge clk) disable iff (!arstn)
    !(i_mem_rvalid && ((r_state == IDLE) || (r_state == REQ))));

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed refill scenarios with random line data, checked against a bench-side model of
// memory beats, line layout, miss latency and cache residency.
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         arstn;
  logic         i_fetch_valid;
  logic [63:0]  i_fetch_addr;
  logic         i_cache_hit;
  logic         o_stall;
  logic [63:0]  o_cache_addr;
  logic         o_cache_we;
  logic [511:0] o_cache_block;
  logic         o_mem_req_valid;
  logic         i_mem_req_ready;
  logic [63:0]  o_mem_addr;
  logic         i_mem_rvalid;
  logic [63:0]  i_mem_rdata;
  logic         i_mem_rlast;
`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0]  o_miss_count;
  logic [31:0]  o_refill_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  logic [63:0] res_blk [8];
  logic [7:0]  res_vld;
  int          res_n;
  logic [31:0] exp_miss;
  logic [31:0] exp_cyc;

  icache_refill_ctrl dut (
    .clk             (clk),
    .arstn           (arstn),
    .i_fetch_valid   (i_fetch_valid),
    .i_fetch_addr    (i_fetch_addr),
    .i_cache_hit     (i_cache_hit),
    .o_stall         (o_stall),
    .o_cache_addr    (o_cache_addr),
    .o_cache_we      (o_cache_we),
    .o_cache_block   (o_cache_block),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_addr      (o_mem_addr),
    .i_mem_rvalid    (i_mem_rvalid),
    .i_mem_rdata     (i_mem_rdata),
`ifdef ICACHE_REFILL_PERF_EN
    .o_miss_count    (o_miss_count),
    .o_refill_cycles (o_refill_cycles),
`endif
    .i_mem_rlast     (i_mem_rlast)
  );

  always #5 clk = ~clk;

  // Cache residency model: a block is resident once the bench has seen its line written.
  always_comb begin
    i_cache_hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (res_vld[i] && (res_blk[i] == (i_fetch_addr & ~64'h3F))) i_cache_hit = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (o_cache_we === 1'b1) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Entered at the sample point of the IDLE miss cycle; leaves at the sample point after WRITE.
  task automatic refill(input logic [63:0] addr, input int rdy_wait, input bit gaps,
                        input bit use_pattern, input bit drop_valid,
                        input bit redirect, input logic [63:0] new_addr);
    logic [63:0]  beat [8];
    logic [511:0] line;
    int k, cyc, gap_cnt, stalls, we0;
    bit phase;
    for (int i = 0; i < 8; i++) begin
      beat[i] = use_pattern ? (64'h0000000100000000 + 64'(i) * 64'h0000000200000002)
                            : {$urandom, $urandom};
      line[i*64 +: 64] = beat[i];
    end
    we0 = we_cnt; stalls = 0; gap_cnt = 0;
    exp_miss++;
    for (int w = 0; w <= rdy_wait; w++) begin
      step();
      i_mem_req_ready = (w == rdy_wait);
      smp();
      chk("req_valid", o_mem_req_valid, 1);
      chk("req_addr", o_mem_addr, addr & ~64'h3F);
      if (o_stall === 1'b1) stalls++;
    end
    k = 0; cyc = 0; phase = 1'b0;
    while (k < 8 && cyc < 64) begin
      step();
      i_mem_req_ready = 1'b0;
      if (redirect && k == 3) i_fetch_addr = new_addr;
      if (drop_valid && k == 2) i_fetch_valid = 1'b0;
      phase = ~phase;
      if (gaps && !phase) begin
        i_mem_rvalid = 1'b0; i_mem_rlast = 1'b0; gap_cnt++;
      end else begin
        i_mem_rvalid = 1'b1; i_mem_rdata = beat[k]; i_mem_rlast = (k == 7); k++;
      end
      smp();
      chk("fill_caddr", o_cache_addr, addr);
      chk("fill_we", o_cache_we, 0);
      if (o_stall === 1'b1) stalls++;
      cyc++;
    end
    chk("fill_bound", k, 8);
    step();
    i_mem_rvalid = 1'b0; i_mem_rlast = 1'b0; i_mem_rdata = '0;
    smp();
    chk("wr_we", o_cache_we, 1);
    chk("wr_caddr", o_cache_addr, addr);
    chk("wr_block", o_cache_block, line);
    if (use_pattern) chk("wr_word1", o_cache_block[63:32], 32'h00000001);
    if (o_stall === 1'b1) stalls++;
    chk("stall_cycles", stalls, 10 + rdy_wait + gap_cnt);
    exp_cyc += 32'(10 + rdy_wait + gap_cnt);
    res_blk[res_n % 8] = addr & ~64'h3F;
    res_vld[res_n % 8] = 1'b1;
    res_n++;
    step();
    chk("we_pulses", we_cnt - we0, 1);
    smp();
    chk("post_we", o_cache_we, 0);
  endtask

  initial begin
    logic [63:0] a, b, c;
    int we0;
    arstn = 1'b0; i_fetch_valid = 1'b0; i_fetch_addr = 64'hABC0;
    i_mem_req_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_mem_rlast = 1'b0;
    res_vld = '0; res_n = 0; exp_miss = '0; exp_cyc = '0;

    repeat (2) smp();
    chk("rst_stall", o_stall, 0);
    chk("rst_reqv", o_mem_req_valid, 0);
    chk("rst_we", o_cache_we, 0);
    chk("rst_maddr", o_mem_addr, 0);
    chk("rst_caddr", o_cache_addr, 64'hABC0);
`ifdef ICACHE_REFILL_PERF_EN
    chk("rst_miss_cnt", o_miss_count, 0);
    chk("rst_cyc_cnt", o_refill_cycles, 0);
`endif
    step(); arstn = 1'b1;

    // Cold miss with zero-wait memory and the fixed beat pattern
    step(); i_fetch_valid = 1'b1; i_fetch_addr = 64'h1044;
    smp();
    chk("miss_idle_stall", o_stall, 1);
    chk("miss_idle_caddr", o_cache_addr, 64'h1044);
    chk("miss_idle_reqv", o_mem_req_valid, 0);
    refill(64'h1044, 0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("cold_post_stall", o_stall, 0);

    // Hits within the resident block, then an invalid fetch to a non-resident block
    for (int i = 0; i < 4; i++) begin
      step();
      a = 64'h1040 + 64'($urandom_range(0, 15)) * 64'd4;
      i_fetch_addr = a;
      smp();
      chk("hit_stall", o_stall, 0);
      chk("hit_reqv", o_mem_req_valid, 0);
      chk("hit_caddr", o_cache_addr, a);
    end
    step(); i_fetch_valid = 1'b0; i_fetch_addr = 64'h9000;
    smp(); step(); smp();
    chk("inval_stall", o_stall, 0);
    chk("inval_reqv", o_mem_req_valid, 0);

    // Back-pressure, rvalid gaps, fetch_valid dropped mid-refill
    a = {$urandom, $urandom} & ~64'h3;
    step(); i_fetch_valid = 1'b1; i_fetch_addr = a;
    smp();
    chk("bp_idle_stall", o_stall, 1);
    refill(a, 5, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    chk("bp_post_stall", o_stall, 0);
    chk("bp_post_reqv", o_mem_req_valid, 0);

    // Redirect during FILL; the new address is looked up once back in IDLE
    a = {$urandom, $urandom} & ~64'h3;
    b = {$urandom, $urandom} & ~64'h3;
    step(); i_fetch_valid = 1'b1; i_fetch_addr = a;
    smp();
    refill(a, 0, 1'b0, 1'b0, 1'b0, 1'b1, b);
    chk("redir_new_stall", o_stall, 1);
    chk("redir_new_caddr", o_cache_addr, b);
    refill(b, 2, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("redir_post_stall", o_stall, 0);
`ifdef ICACHE_REFILL_PERF_EN
    chk("perf_miss_cnt", o_miss_count, exp_miss);
    chk("perf_cyc_cnt", o_refill_cycles, exp_cyc);
`endif

    // Reset after beat 3 of a refill
    c = {$urandom, $urandom} & ~64'h3;
    we0 = we_cnt;
    step(); i_fetch_valid = 1'b1; i_fetch_addr = c;
    smp();
    step(); i_mem_req_ready = 1'b1;
    smp();
    chk("rstmid_reqv", o_mem_req_valid, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      i_mem_req_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = {$urandom, $urandom}; i_mem_rlast = 1'b0;
      smp();
    end
    step(); i_mem_rvalid = 1'b0;
    #2; arstn = 1'b0;
    exp_miss = '0; exp_cyc = '0;
    smp();
    chk("rstmid_reqv_low", o_mem_req_valid, 0);
    chk("rstmid_we_low", o_cache_we, 0);
    chk("rstmid_caddr", o_cache_addr, c);
    step(); arstn = 1'b1;
    smp();
    chk("rstmid_idle_stall", o_stall, 1);
    chk("rstmid_idle_reqv", o_mem_req_valid, 0);
    chk("rstmid_no_write", we_cnt - we0, 0);
    refill(c, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("rstmid_post_stall", o_stall, 0);

    // Second zero-wait miss after reset: two 10-cycle refills in the counters
    a = {$urandom, $urandom} & ~64'h3;
    step(); i_fetch_addr = a;
    smp();
    refill(a, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("final_stall", o_stall, 0);
`ifdef ICACHE_REFILL_PERF_EN
    chk("perf2_miss_cnt", o_miss_count, exp_miss);
    chk("perf2_cyc_cnt", o_refill_cycles, exp_cyc);
    chk("perf2_miss_two", o_miss_count, 32'd2);
    chk("perf2_cyc_twenty", o_refill_cycles, 32'd20);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
